// File: rtl/imem_axil_rd_slave.sv
// AXI-lite read-only instruction memory slave with programmable response latency
// and a write-only backdoor port for loading the memory image.
module imem_axil_rd_slave #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int unsigned LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ARVALID,
  input  logic [ADDR_W-1:0] ARADDR,
  output logic              ARREADY,
  output logic              RVALID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  input  logic              RREADY,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [DATA_W-1:0] bd_wdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          MULTI_CYCLE = (LATENCY > 1);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] bd_idx;
  logic              rd_decerr;
  logic              rd_slverr;
  logic              bd_hit;
  logic              ar_hs;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        rd_resp;

  // Word index wraps in ADDR_W bits; addresses below the base are caught separately.
  assign rd_idx    = (ARADDR - BASE_ADDR) >> 3;
  assign rd_decerr = (ARADDR < BASE_ADDR) || (rd_idx >= ADDR_W'(DEPTH));
  assign rd_slverr = (ARADDR[1:0] != 2'b00);
  assign rd_word   = mem[rd_idx[IDX_W-1:0]];
  assign rd_resp   = rd_decerr ? 2'b11 : (rd_slverr ? 2'b10 : 2'b00);

  assign bd_idx = (bd_addr - BASE_ADDR) >> 3;
  assign bd_hit = (bd_addr >= BASE_ADDR) && (bd_idx < ADDR_W'(DEPTH));

  assign ARREADY = !rst && ((state == IDLE) || ((state == RESP) && RREADY));
  assign ar_hs   = ARVALID && ARREADY;

  // Non-blocking write: a same-edge read of this word still sees the old contents.
  always_ff @(posedge clk) begin
    if (bd_we && bd_hit) begin
      mem[bd_idx[IDX_W-1:0]] <= bd_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= 2'b00;
    end else if (ar_hs) begin
      // Handshake is only possible from IDLE or a completing RESP beat.
      RDATA <= rd_decerr ? '0 : rd_word;
      RRESP <= rd_resp;
      if (MULTI_CYCLE) begin
        state  <= WAIT;
        cnt    <= LAT_M1;
        RVALID <= 1'b0;
      end else begin
        state  <= RESP;
        RVALID <= 1'b1;
      end
    end else begin
      unique case (state)
        IDLE: ;
        WAIT: begin
          if (cnt == 4'd1) begin
            state  <= RESP;
            RVALID <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (RREADY) begin
            state  <= IDLE;
            RVALID <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          RVALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_axil_rd_slave.sv
// Scoreboard bench for imem_axil_rd_slave: three instances at latencies 1, 3 and 4
// share clock, reset and the backdoor port.
module tb_imem_axil_rd_slave;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        arvalid [3];
  logic [31:0] araddr  [3];
  logic        arready [3];
  logic        rvalid  [3];
  logic [63:0] rdata   [3];
  logic [1:0]  rresp   [3];
  logic        rready  [3];
  logic        bd_we;
  logic [31:0] bd_addr;
  logic [63:0] bd_wdata;

  imem_axil_rd_slave #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .ARVALID(arvalid[0]), .ARADDR(araddr[0]), .ARREADY(arready[0]),
    .RVALID(rvalid[0]), .RDATA(rdata[0]), .RRESP(rresp[0]), .RREADY(rready[0]),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );
  imem_axil_rd_slave #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .ARVALID(arvalid[1]), .ARADDR(araddr[1]), .ARREADY(arready[1]),
    .RVALID(rvalid[1]), .RDATA(rdata[1]), .RRESP(rresp[1]), .RREADY(rready[1]),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );
  imem_axil_rd_slave #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .ARVALID(arvalid[2]), .ARADDR(araddr[2]), .ARREADY(arready[2]),
    .RVALID(rvalid[2]), .RDATA(rdata[2]), .RRESP(rresp[2]), .RREADY(rready[2]),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  r;
  } exp_t;

  exp_t        sb [$];
  logic [63:0] img [int unsigned];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic exp_t model(input logic [31:0] a);
    logic [31:0] idx;
    exp_t e;
    idx = (a - BASE) >> 3;
    if (a < BASE || idx >= DEPTH) begin
      e = '{d: 64'h0, r: 2'b11};
    end else begin
      e.d = img.exists(idx) ? img[idx] : 64'hx;
      e.r = (a[1:0] != 2'b00) ? 2'b10 : 2'b00;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [31:0] a, input logic [63:0] d);
    logic [31:0] idx;
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    step();
    bd_we = 1'b0;
    idx = (a - BASE) >> 3;
    if (a >= BASE && idx < DEPTH) img[idx] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      arvalid[i] = 1'b0; araddr[i] = '0; rready[i] = 1'b0;
    end
    #3;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rvalid[i] !== 1'b0 || rdata[i] !== 64'h0 || rresp[i] !== 2'b00 || arready[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state inst%0d: got rv=%b rd=%h rr=%b ar=%b, want 0 0 0 0",
                 i, rvalid[i], rdata[i], rresp[i], arready[i]);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (arready[i] !== 1'b1 || rvalid[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after_reset inst%0d: got ar=%b rv=%b, want 1 0",
                 i, arready[i], rvalid[i]);
      end
    end
    step();
  endtask

  task automatic test_basic();
    exp_t e;
    bd_write(BASE, 64'h0000_0013_0010_0093);
    sb.push_back('{d: 64'h0000_0013_0010_0093, r: 2'b00});
    arvalid[0] = 1'b1; araddr[0] = BASE; rready[0] = 1'b1;
    @(negedge clk);
    vectors++;
    if (arready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_arready: got %b want 1", arready[0]);
    end
    step();
    arvalid[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (rvalid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency1: rvalid got %b want 1", rvalid[0]);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (rdata[0] !== e.d || rresp[0] !== e.r) begin
        miscompares++;
        $display("FAIL basic_beat: got %h/%b want %h/%b", rdata[0], rresp[0], e.d, e.r);
      end
    end
    step();
    vectors++;
    if (rvalid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_complete: rvalid got %b want 0", rvalid[0]);
    end
    sb.delete();
  endtask

  task automatic test_latency();
    exp_t e;
    int   n;
    bit   got;
    sb.push_back(model(BASE + 32'd4));
    arvalid[1] = 1'b1; araddr[1] = BASE + 32'd4; rready[1] = 1'b1;
    @(negedge clk);
    vectors++;
    if (arready[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL lat3_arready: got %b want 1", arready[1]);
    end
    step();
    arvalid[1] = 1'b0;
    n = 1; got = 1'b0;
    while (n <= 20 && !got) begin
      @(negedge clk);
      if (rvalid[1] === 1'b1) begin
        got = 1'b1;
      end else begin
        vectors++;
        if (arready[1] !== 1'b0) begin
          miscompares++;
          $display("FAIL lat3_wait_arready: cycle %0d got %b want 0", n, arready[1]);
        end
        step();
        n++;
      end
    end
    vectors++;
    if (!got || n != 3) begin
      miscompares++;
      $display("FAIL lat3_cycles: got %0d (seen=%b) want 3", n, got);
    end
    if (got) begin
      e = sb.pop_front();
      vectors++;
      if (rdata[1] !== e.d || rresp[1] !== e.r) begin
        miscompares++;
        $display("FAIL lat3_beat: got %h/%b want %h/%b", rdata[1], rresp[1], e.d, e.r);
      end
    end
    step();
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    exp_t        e;
    int          nb;
    bd_write(BASE + 32'd8,  64'h1111_2222_3333_4444);
    bd_write(BASE + 32'd16, 64'h5555_6666_7777_8888);
    addrs[0] = BASE; addrs[1] = BASE + 32'd8; addrs[2] = BASE + 32'd16;
    rready[0] = 1'b1;
    nb = 0;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        arvalid[0] = 1'b1; araddr[0] = addrs[c];
        sb.push_back(model(addrs[c]));
      end else begin
        arvalid[0] = 1'b0;
      end
      @(negedge clk);
      if (c < 3) begin
        vectors++;
        if (arready[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_arready: cycle %0d got %b want 1", c, arready[0]);
        end
      end
      if (rvalid[0] === 1'b1) begin
        vectors++;
        if (c != nb + 1 || sb.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_timing: beat %0d at cycle %0d want cycle %0d", nb, c, nb + 1);
        end else begin
          e = sb.pop_front();
          if (rdata[0] !== e.d || rresp[0] !== e.r) begin
            miscompares++;
            $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", nb, rdata[0], rresp[0], e.d, e.r);
          end
        end
        nb++;
      end
      step();
    end
    vectors++;
    if (nb != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d beats want 3", nb);
    end
    sb.delete();
  endtask

  task automatic test_backpressure();
    exp_t e;
    sb.push_back(model(BASE + 32'd8));
    arvalid[0] = 1'b1; araddr[0] = BASE + 32'd8; rready[0] = 1'b0;
    @(negedge clk);
    step();
    arvalid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (rvalid[0] !== 1'b1 || arready[0] !== 1'b0 ||
          rdata[0] !== sb[0].d || rresp[0] !== sb[0].r) begin
        miscompares++;
        $display("FAIL stall%0d: got rv=%b ar=%b %h/%b want 1 0 %h/%b",
                 k, rvalid[0], arready[0], rdata[0], rresp[0], sb[0].d, sb[0].r);
      end
      step();
    end
    rready[0] = 1'b1;
    @(negedge clk);
    vectors++;
    if (rvalid[0] !== 1'b1 || arready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got rv=%b ar=%b want 1 1", rvalid[0], arready[0]);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (rdata[0] !== e.d || rresp[0] !== e.r) begin
        miscompares++;
        $display("FAIL stall_beat: got %h/%b want %h/%b", rdata[0], rresp[0], e.d, e.r);
      end
    end
    step();
    vectors++;
    if (rvalid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_done: rvalid got %b want 0", rvalid[0]);
    end
    sb.delete();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    exp_t        e;
    addrs[0] = 32'h7FFF_FFF8; addrs[1] = BASE + 8 * DEPTH;
    addrs[2] = 32'h8000_0002; addrs[3] = 32'h7FFF_FFFA;
    sb.push_back('{d: 64'h0, r: 2'b11});
    sb.push_back('{d: 64'h0, r: 2'b11});
    sb.push_back('{d: 64'h0000_0013_0010_0093, r: 2'b10});
    sb.push_back('{d: 64'h0, r: 2'b11});
    rready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      arvalid[0] = 1'b1; araddr[0] = addrs[k];
      @(negedge clk);
      step();
      arvalid[0] = 1'b0;
      @(negedge clk);
      vectors++;
      if (rvalid[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL err%0d_valid: got %b want 1", k, rvalid[0]);
      end else begin
        e = sb.pop_front();
        if (rdata[0] !== e.d || rresp[0] !== e.r) begin
          miscompares++;
          $display("FAIL err%0d_beat addr %h: got %h/%b want %h/%b",
                   k, addrs[k], rdata[0], rresp[0], e.d, e.r);
        end
      end
      step();
    end
    sb.delete();
  endtask

  task automatic test_backdoor();
    logic [31:0] addrs [3];
    exp_t        e;
    bd_write(BASE + 32'd32, 64'hAAAA_0000_BBBB_0001);
    bd_write(BASE + 8 * (DEPTH - 1), 64'h0123_4567_89AB_CDEF);
    // Both of these fall outside the array and must not alias onto any word.
    bd_write(BASE - 32'd8, 64'hDEAD_DEAD_DEAD_DEAD);
    bd_write(BASE + 8 * DEPTH, 64'hBEEF_BEEF_BEEF_BEEF);
    // Same-cycle read and backdoor write of one word returns the old data.
    sb.push_back('{d: 64'hAAAA_0000_BBBB_0001, r: 2'b00});
    bd_we = 1'b1; bd_addr = BASE + 32'd32; bd_wdata = 64'hCCCC_0000_DDDD_0002;
    arvalid[0] = 1'b1; araddr[0] = BASE + 32'd32; rready[0] = 1'b1;
    step();
    bd_we = 1'b0; arvalid[0] = 1'b0;
    img[4] = 64'hCCCC_0000_DDDD_0002;
    @(negedge clk);
    vectors++;
    if (rvalid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL collide_valid: got %b want 1", rvalid[0]);
    end else begin
      e = sb.pop_front();
      if (rdata[0] !== e.d || rresp[0] !== e.r) begin
        miscompares++;
        $display("FAIL collide_beat: got %h/%b want %h/%b", rdata[0], rresp[0], e.d, e.r);
      end
    end
    step();
    addrs[0] = BASE + 32'd32; addrs[1] = BASE; addrs[2] = BASE + 8 * (DEPTH - 1);
    for (int k = 0; k < 3; k++) begin
      sb.push_back(model(addrs[k]));
      arvalid[0] = 1'b1; araddr[0] = addrs[k];
      @(negedge clk);
      step();
      arvalid[0] = 1'b0;
      @(negedge clk);
      vectors++;
      if (rvalid[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL bd%0d_valid: got %b want 1", k, rvalid[0]);
      end else begin
        e = sb.pop_front();
        if (rdata[0] !== e.d || rresp[0] !== e.r) begin
          miscompares++;
          $display("FAIL bd%0d_beat addr %h: got %h/%b want %h/%b",
                   k, addrs[k], rdata[0], rresp[0], e.d, e.r);
        end
      end
      step();
    end
    sb.delete();
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int   n;
    bit   got;
    bd_write(BASE + 32'd24, 64'hFEED_FACE_0BAD_F00D);
    // Reset while the LATENCY=4 instance is in WAIT.
    arvalid[2] = 1'b1; araddr[2] = BASE + 32'd24; rready[2] = 1'b1;
    @(negedge clk);
    step();
    arvalid[2] = 1'b0;
    step();
    rst = 1'b1;
    #1;
    vectors++;
    if (rvalid[2] !== 1'b0 || arready[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wait: got rv=%b ar=%b want 0 0", rvalid[2], arready[2]);
    end
    @(posedge clk); #1 rst = 1'b0;
    step();
    // Reset while a beat is being presented: RVALID must drop without a clock edge.
    rready[2] = 1'b0;
    arvalid[2] = 1'b1; araddr[2] = BASE + 32'd24;
    @(negedge clk);
    step();
    arvalid[2] = 1'b0;
    n = 0;
    while (n < 20 && rvalid[2] !== 1'b1) begin
      step();
      n++;
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (rvalid[2] !== 1'b0 || rdata[2] !== 64'h0 || rresp[2] !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_resp: got rv=%b rd=%h rr=%b want 0 0 0", rvalid[2], rdata[2], rresp[2]);
    end
    @(posedge clk); #1 rst = 1'b0;
    step();
    // Array contents survive reset.
    rready[2] = 1'b1;
    sb.push_back(model(BASE + 32'd24));
    arvalid[2] = 1'b1; araddr[2] = BASE + 32'd24;
    @(negedge clk);
    step();
    arvalid[2] = 1'b0;
    n = 1; got = 1'b0;
    while (n <= 20 && !got) begin
      @(negedge clk);
      if (rvalid[2] === 1'b1) got = 1'b1;
      else begin
        step();
        n++;
      end
    end
    vectors++;
    if (!got || n != 4) begin
      miscompares++;
      $display("FAIL lat4_cycles: got %0d (seen=%b) want 4", n, got);
    end
    if (got) begin
      e = sb.pop_front();
      vectors++;
      if (rdata[2] !== e.d || rresp[2] !== e.r) begin
        miscompares++;
        $display("FAIL rst_survive: got %h/%b want %h/%b", rdata[2], rresp[2], e.d, e.r);
      end
    end
    step();
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_backdoor();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
